// File: rtl/baud_gen_frac.sv
// Fractional baud tick generator: oversample tick every dvsr+1 (+fractional carry) cycles, bit tick every OSR oversample ticks.
// Ticks are a same-cycle decode of registered state; no backpressure, en low freezes, shadowed divisor swaps only on a boundary/idle/realign.
module baud_gen_frac #(
    parameter int DVSR_BITS    = 16,
    parameter int FRAC_BITS    = 4,
    parameter int OSR          = 16,
    parameter int DEFAULT_DVSR = 66,
    parameter int DEFAULT_FRAC = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 dvsr_wr,
    input  logic [DVSR_BITS-1:0] dvsr_in,
    input  logic [FRAC_BITS-1:0] frac_in,
    output logic                 tick_os,
    output logic                 tick_bit,
    output logic                 dvsr_pend,
    output logic [DVSR_BITS-1:0] dvsr_cur,
    output logic [FRAC_BITS-1:0] frac_cur
);

    localparam int CNT_W = DVSR_BITS + 1;
    localparam int OS_W  = (OSR > 2) ? $clog2(OSR) : 1;
    localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OSR - 1);
    localparam logic [DVSR_BITS-1:0] DEF_DVSR = DVSR_BITS'(DEFAULT_DVSR);
    localparam logic [FRAC_BITS-1:0] DEF_FRAC = FRAC_BITS'(DEFAULT_FRAC);

    logic [CNT_W-1:0]     r_count;
    logic [OS_W-1:0]      r_os_cnt;
    logic [FRAC_BITS-1:0] r_acc;
    logic                 r_ext;
    logic [DVSR_BITS-1:0] r_dvsr_cur;
    logic [FRAC_BITS-1:0] r_frac_cur;
    logic [DVSR_BITS-1:0] r_sh_dvsr;
    logic [FRAC_BITS-1:0] r_sh_frac;
    logic                 r_pend;

    logic [CNT_W-1:0]     w_limit;
    logic [FRAC_BITS:0]   w_frac_sum;
    logic                 w_tick_os;
    logic                 w_os_last;
    logic                 w_apply;

    // One extra count bit so dvsr_cur + carry never wraps.
    assign w_limit    = {1'b0, r_dvsr_cur} + CNT_W'(r_ext);
    assign w_frac_sum = {1'b0, r_acc} + {1'b0, r_frac_cur};
    assign w_tick_os  = reset_n & en & ~clr & (r_count == w_limit);
    assign w_os_last  = (r_os_cnt == OS_LAST);
    assign w_apply    = r_pend & (w_tick_os | ~en | clr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_os_cnt <= '0;
            r_acc    <= '0;
            r_ext    <= 1'b0;
        end else if (clr) begin
            r_count  <= '0;
            r_os_cnt <= '0;
            r_acc    <= '0;
            r_ext    <= 1'b0;
        end else if (en) begin
            if (w_tick_os) begin
                r_count        <= '0;
                {r_ext, r_acc} <= w_frac_sum;
                r_os_cnt       <= w_os_last ? '0 : r_os_cnt + OS_W'(1);
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // A write coinciding with an apply lands in the shadow after the old shadow moves out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dvsr_cur <= DEF_DVSR;
            r_frac_cur <= DEF_FRAC;
            r_sh_dvsr  <= DEF_DVSR;
            r_sh_frac  <= DEF_FRAC;
            r_pend     <= 1'b0;
        end else begin
            if (w_apply) begin
                r_dvsr_cur <= r_sh_dvsr;
                r_frac_cur <= r_sh_frac;
            end
            if (dvsr_wr) begin
                r_sh_dvsr <= dvsr_in;
                r_sh_frac <= frac_in;
            end
            if (dvsr_wr) begin
                r_pend <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign tick_os   = w_tick_os;
    assign tick_bit  = w_tick_os & w_os_last;
    assign dvsr_pend = r_pend;
    assign dvsr_cur  = r_dvsr_cur;
    assign frac_cur  = r_frac_cur;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: event-level reference model feeds expectation queues, a monitor pops and compares.
module tb_baud_gen_frac;

    localparam int OSR      = 16;
    localparam int DEF_DVSR = 66;
    localparam int DEF_FRAC = 0;
    localparam int FRAC_ONE = 16;
    localparam int CNT_MOD  = 1 << 17;

    typedef struct {
        int   cyc;
        logic is_bit;
    } tick_t;

    typedef struct {
        int   cyc;
        int   dv;
        int   fr;
        logic pend;
    } stat_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        clr;
    logic        dvsr_wr;
    logic [15:0] dvsr_in;
    logic [3:0]  frac_in;
    logic        tick_os;
    logic        tick_bit;
    logic        dvsr_pend;
    logic [15:0] dvsr_cur;
    logic [3:0]  frac_cur;

    baud_gen_frac dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .clr       (clr),
        .dvsr_wr   (dvsr_wr),
        .dvsr_in   (dvsr_in),
        .frac_in   (frac_in),
        .tick_os   (tick_os),
        .tick_bit  (tick_bit),
        .dvsr_pend (dvsr_pend),
        .dvsr_cur  (dvsr_cur),
        .frac_cur  (frac_cur)
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_pass = 0;
    int    cyc    = 0;
    tick_t tick_q[$];
    stat_t stat_q[$];

    // Reference model: absolute cycle of the next tick, current interval limit,
    // fractional phase in 1/16 cycles, ticks since realign, active and shadow divisors.
    int m_next, m_lim, m_ext, m_fph, m_nt, m_dv, m_fr, m_sdv, m_sfr;
    bit m_pend;

    function automatic void chk(input string name, input int c, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, c, act, exp);
    endfunction

    function automatic int m_count(input int c);
        return m_lim - (m_next - c);
    endfunction

    function automatic void model_reset(input int c);
        m_dv = DEF_DVSR;  m_fr = DEF_FRAC;
        m_sdv = DEF_DVSR; m_sfr = DEF_FRAC;
        m_pend = 1'b0;
        m_ext = 0; m_fph = 0; m_nt = 0;
        m_lim = m_dv;
        m_next = c + 1 + m_dv;
    endfunction

    function automatic void model_cycle(input logic t_en, input logic t_clr, input logic t_wr,
                                        input int t_dv, input int t_fr, input logic t_rst_n);
        stat_t s;
        tick_t t;
        bit    tk, ap;
        int    ndv, nfr, cnt;
        if (!t_rst_n) model_reset(cyc);
        s.cyc = cyc; s.dv = m_dv; s.fr = m_fr; s.pend = m_pend;
        stat_q.push_back(s);
        if (!t_rst_n) return;
        tk = t_en && !t_clr && (cyc == m_next);
        if (tk) begin
            t.cyc = cyc;
            t.is_bit = ((m_nt % OSR) == OSR - 1);
            tick_q.push_back(t);
        end
        ap  = m_pend && (tk || !t_en || t_clr);
        ndv = ap ? m_sdv : m_dv;
        nfr = ap ? m_sfr : m_fr;
        if (t_clr) begin
            m_ext = 0; m_fph = 0; m_nt = 0;
            m_lim = ndv;
            m_next = cyc + 1 + ndv;
        end else if (!t_en) begin
            cnt = m_count(cyc);
            m_lim = ndv + m_ext;
            m_next = cyc + 1 + (((m_lim - cnt) % CNT_MOD) + CNT_MOD) % CNT_MOD;
        end else if (tk) begin
            m_fph = m_fph + m_fr;
            m_ext = m_fph / FRAC_ONE;
            m_fph = m_fph % FRAC_ONE;
            m_nt++;
            m_lim = ndv + m_ext;
            m_next = cyc + 1 + m_lim;
        end
        m_dv = ndv;
        m_fr = nfr;
        if (ap) m_pend = 1'b0;
        if (t_wr) begin
            m_sdv = t_dv; m_sfr = t_fr; m_pend = 1'b1;
        end
    endfunction

    task automatic step(input logic t_en, input logic t_clr, input logic t_wr,
                        input int t_dv, input int t_fr, input logic t_rst_n);
        @(posedge clk);
        #1;
        reset_n = t_rst_n;
        en      = t_en;
        clr     = t_clr;
        dvsr_wr = t_wr;
        dvsr_in = 16'(t_dv);
        frac_in = 4'(t_fr);
        cyc++;
        model_cycle(t_en, t_clr, t_wr, t_dv, t_fr, t_rst_n);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic wait_count(input int target, input bit need_idle);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (m_count(cyc + 1) == target && !(need_idle && m_pend)) break;
            run(1);
        end
        if (k >= 3000) begin
            n_chk++;
            $display("FAIL wait_count cycle=%0d actual=%0d expected=%0d", cyc, m_count(cyc + 1), target);
        end
    endtask

    // Monitor: status every cycle, ticks matched against the expected-tick queue.
    initial begin
        stat_t s;
        tick_t t;
        forever begin
            @(negedge clk);
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                chk("dvsr_cur", s.cyc, dvsr_cur, s.dv);
                chk("frac_cur", s.cyc, frac_cur, s.fr);
                chk("dvsr_pend", s.cyc, dvsr_pend, s.pend);
                if (tick_os) begin
                    if (tick_q.size() == 0) begin
                        chk("tick_os_spurious", s.cyc, 1, 0);
                    end else begin
                        t = tick_q.pop_front();
                        chk("tick_os_cycle", s.cyc, s.cyc, t.cyc);
                        chk("tick_bit", s.cyc, tick_bit, t.is_bit);
                    end
                end else begin
                    chk("tick_bit_idle", s.cyc, tick_bit, 0);
                    if (tick_q.size() > 0 && tick_q[0].cyc <= s.cyc) begin
                        t = tick_q.pop_front();
                        chk("tick_os_missing", t.cyc, 0, 1);
                    end
                end
            end
        end
    end

    initial begin
        int c0;
        bit low_ok;
        reset_n = 1'b0; en = 1'b0; clr = 1'b0; dvsr_wr = 1'b0;
        dvsr_in = '0;   frac_in = '0;
        model_reset(0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

        // Defaults: 67-cycle intervals, bit tick every 1072 cycles.
        run(2200);

        // Mid-interval write 9 + 8/16: current interval finishes, then 10/11 alternation.
        wait_count(30, 1'b0);
        step(1'b1, 1'b0, 1'b1, 9, 8, 1'b1);
        run(400);

        // en low for 20 cycles mid-interval, then a write made while en is low.
        wait_count(5, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        run(100);
        wait_count(2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 12, 3, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        run(200);

        // Re-align at count=30, os_cnt=5 under the default divisor.
        step(1'b1, 1'b0, 1'b1, 66, 0, 1'b1);
        c0 = 0;
        while (c0 < 4000 && !(!m_pend && m_count(cyc + 1) == 30 && (m_nt % OSR) == 5)) begin
            run(1);
            c0++;
        end
        if (c0 >= 4000) begin
            n_chk++;
            $display("FAIL wait_align cycle=%0d actual=%0d expected=%0d", cyc, m_count(cyc + 1), 30);
        end
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        run(1200);

        // Two writes before a boundary: only 0/0 lands, then a tick every cycle.
        wait_count(10, 1'b1);
        step(1'b1, 1'b0, 1'b1, 20, 5, 1'b1);
        step(1'b1, 1'b0, 1'b1, 0, 0, 1'b1);
        run(100);

        // Random traffic; en only drops when a pending divisor cannot land below the live count.
        for (int i = 0; i < 3000; i++) begin
            low_ok = !m_pend || (m_sdv + m_ext >= m_count(cyc + 1));
            step(!(low_ok && $urandom_range(0, 99) < 8),
                 $urandom_range(0, 199) < 2,
                 $urandom_range(0, 99) < 3,
                 int'($urandom_range(0, 20)), int'($urandom_range(0, 15)), 1'b1);
        end

        // Async reset at count=40 with a write pending.
        step(1'b1, 1'b0, 1'b1, 66, 0, 1'b1);
        wait_count(38, 1'b1);
        step(1'b1, 1'b0, 1'b1, 5, 7, 1'b1);
        run(1);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run(200);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("tick_queue_drained", cyc, tick_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
